pipe_ctrl: RTL and testbench

//  Central pipeline sequencer for the 5-stage core: merges per-stage stall requests into the 6-bit stall

---
 rtl/pipe_ctrl.sv | 131 +++++++++++++
 tb/tb_pipe_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: merges per-stage stall requests into the stall vector,
// arbitrates jump/interrupt redirects (holding them across PC stalls) and
// keeps stall statistics with a sticky stuck-stall flag.
module pipe_ctrl #(
  parameter int ADDR_WIDTH = 32,
  parameter int CNT_WIDTH  = 32,
  parameter int TIMEOUT    = 1024
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  stallreq_if_i,
  input  logic                  stallreq_id_i,
  input  logic                  stallreq_ex_i,
  input  logic                  stallreq_mem_i,
  input  logic                  jump_req_i,
  input  logic [ADDR_WIDTH-1:0] jump_addr_i,
  input  logic                  int_req_i,
  input  logic [ADDR_WIDTH-1:0] int_addr_i,
  output logic [5:0]            stall_o,
  output logic                  flush_jump_o,
  output logic                  flush_int_o,
  output logic [ADDR_WIDTH-1:0] new_pc_o,
  output logic                  int_taken_o,
  output logic [CNT_WIDTH-1:0]  stall_cnt_o,
  output logic                  timeout_o
);

  localparam int RUN_W = $clog2(TIMEOUT + 1);
  localparam logic [RUN_W-1:0] RUN_MAX  = RUN_W'(TIMEOUT);
  localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, PEND_JUMP, PEND_INT} state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   pend_addr_q, pend_addr_d;
  logic [5:0]              stall_vec;
  logic                    stall_pc;
  logic [CNT_WIDTH-1:0]    stall_cnt_q;
  logic [RUN_W-1:0]        run_cnt_q;
  logic                    timeout_q;

  // Saturating increment: the performance counter sticks at all-ones.
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

  // Highest stalled stage wins; every stage upstream of it is frozen too.
  // Reset forces the vector low so all outputs read 0 while rst_i is high.
  always_comb begin
    stall_vec = 6'b000000;
    if (rst_i)               stall_vec = 6'b000000;
    else if (stallreq_mem_i) stall_vec = 6'b011111;
    else if (stallreq_ex_i)  stall_vec = 6'b001111;
    else if (stallreq_id_i)  stall_vec = 6'b000111;
    else if (stallreq_if_i)  stall_vec = 6'b000011;
  end

  assign stall_o  = stall_vec;
  assign stall_pc = stall_vec[0];

  // Redirect arbitration: a fresh interrupt beats a held interrupt, which
  // beats a fresh jump, which beats a held jump. Redirects raised while the
  // PC is stalled are parked until the stall releases.
  always_comb begin
    state_d      = state_q;
    pend_addr_d  = pend_addr_q;
    flush_jump_o = 1'b0;
    flush_int_o  = 1'b0;
    new_pc_o     = '0;
    if (rst_i) begin
      state_d     = IDLE;
      pend_addr_d = '0;
    end else if (!stall_pc) begin
      state_d     = IDLE;
      pend_addr_d = '0;
      if (int_req_i) begin
        flush_int_o = 1'b1;
        new_pc_o    = int_addr_i;
      end else if (state_q == PEND_INT) begin
        flush_int_o = 1'b1;
        new_pc_o    = pend_addr_q;
      end else if (jump_req_i) begin
        flush_jump_o = 1'b1;
        new_pc_o     = jump_addr_i;
      end else if (state_q == PEND_JUMP) begin
        flush_jump_o = 1'b1;
        new_pc_o     = pend_addr_q;
      end
    end else begin
      if (int_req_i) begin
        state_d     = PEND_INT;
        pend_addr_d = int_addr_i;
      end else if (jump_req_i && state_q != PEND_INT) begin
        state_d     = PEND_JUMP;
        pend_addr_d = jump_addr_i;
      end
    end
  end

  assign int_taken_o = flush_int_o;

  // Redirect FSM state and parked target.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      pend_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      pend_addr_q <= pend_addr_d;
    end
  end

  // Stall statistics: total stalled cycles and current consecutive run.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
      run_cnt_q   <= '0;
      timeout_q   <= 1'b0;
    end else if (stall_pc) begin
      stall_cnt_q <= sat_inc(stall_cnt_q);
      if (run_cnt_q != RUN_MAX) run_cnt_q <= run_cnt_q + RUN_W'(1);
      if (run_cnt_q >= RUN_LAST) timeout_q <= 1'b1;
    end else begin
      run_cnt_q <= '0;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign timeout_o   = timeout_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Randomised scoreboard bench for pipe_ctrl with directed scenarios up front.
module tb_pipe_ctrl;

  localparam int AW = 32;
  localparam int CW = 8;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          rst_i;
  logic          stallreq_if_i, stallreq_id_i, stallreq_ex_i, stallreq_mem_i;
  logic          jump_req_i, int_req_i;
  logic [AW-1:0] jump_addr_i, int_addr_i;
  logic [5:0]    stall_o;
  logic          flush_jump_o, flush_int_o, int_taken_o, timeout_o;
  logic [AW-1:0] new_pc_o;
  logic [CW-1:0] stall_cnt_o;

  always #5 clk = ~clk;

  pipe_ctrl #(.ADDR_WIDTH(AW), .CNT_WIDTH(CW), .TIMEOUT(TO)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .stallreq_if_i(stallreq_if_i), .stallreq_id_i(stallreq_id_i),
    .stallreq_ex_i(stallreq_ex_i), .stallreq_mem_i(stallreq_mem_i),
    .jump_req_i(jump_req_i), .jump_addr_i(jump_addr_i),
    .int_req_i(int_req_i), .int_addr_i(int_addr_i),
    .stall_o(stall_o), .flush_jump_o(flush_jump_o), .flush_int_o(flush_int_o),
    .new_pc_o(new_pc_o), .int_taken_o(int_taken_o),
    .stall_cnt_o(stall_cnt_o), .timeout_o(timeout_o)
  );

  typedef struct {
    logic [5:0]    stall;
    logic          fj;
    logic          fi;
    logic          it;
    logic [AW-1:0] pc;
    logic [CW-1:0] cnt;
    logic          to;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  // Reference model state: one parked redirect, counters as plain integers.
  bit            p_valid, p_int;
  logic [AW-1:0] p_addr;
  longint        m_cnt;
  int            m_run;
  bit            m_to;

  task automatic model_reset();
    p_valid = 0; p_int = 0; p_addr = '0;
    m_cnt = 0; m_run = 0; m_to = 0;
  endtask

  // One clock cycle of stimulus; sreq = {mem, ex, id, if}.
  task automatic drive(input bit r, input bit [3:0] sreq,
                       input bit jr, input logic [AW-1:0] ja,
                       input bit ir, input logic [AW-1:0] ia);
    exp_t e;
    int   rank;
    bit   st;
    @(posedge clk); #1;
    rst_i = r;
    {stallreq_mem_i, stallreq_ex_i, stallreq_id_i, stallreq_if_i} = sreq;
    jump_req_i = jr; jump_addr_i = ja; int_req_i = ir; int_addr_i = ia;
    cyc++;
    e.stall = '0; e.fj = 0; e.fi = 0; e.it = 0; e.pc = '0; e.cnt = '0; e.to = 0;
    if (r) begin
      model_reset();
    end else begin
      rank = sreq[3] ? 4 : sreq[2] ? 3 : sreq[1] ? 2 : sreq[0] ? 1 : 0;
      st   = (rank != 0);
      if (st) e.stall = 6'((1 << (rank + 1)) - 1);
      e.cnt = CW'(m_cnt);
      e.to  = m_to;
      if (!st) begin
        if (ir)                      begin e.fi = 1; e.pc = ia;     end
        else if (p_valid && p_int)   begin e.fi = 1; e.pc = p_addr; end
        else if (jr)                 begin e.fj = 1; e.pc = ja;     end
        else if (p_valid)            begin e.fj = 1; e.pc = p_addr; end
        p_valid = 0; p_int = 0; p_addr = '0;
        m_run = 0;
      end else begin
        if (ir) begin
          p_valid = 1; p_int = 1; p_addr = ia;
        end else if (jr && !(p_valid && p_int)) begin
          p_valid = 1; p_int = 0; p_addr = ja;
        end
        if (m_cnt < (longint'(1) << CW) - 1) m_cnt++;
        m_run++;
        if (m_run >= TO) m_to = 1;
      end
      e.it = e.fi;
    end
    sb.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 4'b0000, 0, '0, 0, '0);
  endtask

  // Monitor: every cycle the DUT presents a result; compare against the queue.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if (stall_o !== e.stall || flush_jump_o !== e.fj || flush_int_o !== e.fi ||
            int_taken_o !== e.it || new_pc_o !== e.pc || stall_cnt_o !== e.cnt ||
            timeout_o !== e.to) begin
          errors++;
          $display("FAIL cycle%0d got stall=%h fj=%b fi=%b it=%b pc=%h cnt=%0d to=%b exp stall=%h fj=%b fi=%b it=%b pc=%h cnt=%0d to=%b",
                   cyc, stall_o, flush_jump_o, flush_int_o, int_taken_o, new_pc_o,
                   stall_cnt_o, timeout_o, e.stall, e.fj, e.fi, e.it, e.pc, e.cnt, e.to);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit [3:0] s;
    rst_i = 1; {stallreq_mem_i, stallreq_ex_i, stallreq_id_i, stallreq_if_i} = '0;
    jump_req_i = 0; int_req_i = 0; jump_addr_i = '0; int_addr_i = '0;
    model_reset();
    drive(1, 4'b0000, 0, '0, 0, '0);
    drive(1, 4'b0000, 0, '0, 0, '0);
    idle(1);
    // stall priority
    drive(0, 4'b1001, 0, '0, 0, '0);
    drive(0, 4'b0010, 0, '0, 0, '0);
    drive(0, 4'b0100, 0, '0, 0, '0);
    drive(0, 4'b0001, 0, '0, 0, '0);
    idle(1);
    // direct jump, direct interrupt, simultaneous (interrupt wins)
    drive(0, 4'b0000, 1, 32'h100, 0, '0);
    idle(1);
    drive(0, 4'b0000, 0, '0, 1, 32'h40);
    drive(0, 4'b0000, 1, 32'h500, 1, 32'h44);
    // held jump under 3-cycle ex stall
    drive(0, 4'b0100, 1, 32'h200, 0, '0);
    drive(0, 4'b0100, 0, '0, 0, '0);
    drive(0, 4'b0100, 0, '0, 0, '0);
    idle(2);
    // collision: pending jump replaced by interrupt
    drive(0, 4'b1000, 1, 32'h300, 0, '0);
    drive(0, 4'b1000, 0, '0, 1, 32'h80);
    idle(2);
    // pending interrupt ignores jump at release; overwritten by a newer interrupt
    drive(0, 4'b0010, 0, '0, 1, 32'h90);
    drive(0, 4'b0010, 1, 32'h600, 1, 32'h94);
    drive(0, 4'b0000, 1, 32'h604, 0, '0);
    // pending jump, newer jump in release cycle wins
    drive(0, 4'b0001, 1, 32'h700, 0, '0);
    drive(0, 4'b0000, 1, 32'h704, 0, '0);
    // pending jump, interrupt in release cycle wins
    drive(0, 4'b0001, 1, 32'h710, 0, '0);
    drive(0, 4'b0000, 0, '0, 1, 32'h98);
    idle(1);
    // reset mid-stall with a pending jump, stall still requested
    drive(0, 4'b0100, 1, 32'h800, 0, '0);
    drive(1, 4'b0100, 0, '0, 0, '0);
    drive(0, 4'b0100, 0, '0, 0, '0);
    idle(2);
    // timeout: 3-cycle stall does not trip, 4-cycle stall does and sticks
    drive(1, 4'b0000, 0, '0, 0, '0);
    for (int i = 0; i < 3; i++) drive(0, 4'b0001, 0, '0, 0, '0);
    idle(2);
    drive(1, 4'b0000, 0, '0, 0, '0);
    for (int i = 0; i < 4; i++) drive(0, 4'b0001, 0, '0, 0, '0);
    idle(3);
    // long stall to saturate the performance counter
    for (int i = 0; i < 300; i++) drive(0, 4'b0001, 0, '0, 0, '0);
    idle(2);
    // random traffic
    for (int i = 0; i < 1500; i++) begin
      s = '0;
      for (int k = 0; k < 4; k++) s[k] = ($urandom_range(0, 4) == 0);
      drive(($urandom_range(0, 199) == 0), s,
            ($urandom_range(0, 3) == 0), $urandom(),
            ($urandom_range(0, 6) == 0), $urandom());
    end
    idle(1);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
